fifo_param: RTL and testbench
=============================

// Module: fifo_param
// PURPOSE
//  Parametrised synchronous FIFO for the PCIe transaction-layer queues; next generation of the 12-bit x 8 FIFO.
//  Configurable width/depth, true full/empty/count, sticky overflow/underflow errors, and thresholds coherent with count.
//  Sits between a referee (push side) and the arbiter/consumer (pop side), sequenced by the shared one-hot state bus.
// PARAMETERS
//  DATA_W   12  data word width in bits
//  ADDR_W   3   address width; DEPTH = 2**ADDR_W entries
//  AF_RST   6   almost-full threshold loaded on reset (must fit ADDR_W+1 bits)
//  AE_RST   1   almost-empty threshold loaded on reset
// PORTS
//  clk           in   1         rising-edge clock
//  reset         in   1         asynchronous, active-high reset
//  state         in   4         one-hot control: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE
//  push          in   1         write request (honoured in ACTIVE only)
//  pop           in   1         read request (honoured in ACTIVE only)
//  data_in       in   DATA_W    write data, sampled on push
//  umbral_AF_in  in   ADDR_W+1  almost-full threshold, latched in INIT
//  umbral_AE_in  in   ADDR_W+1  almost-empty threshold, latched in INIT
//  data_out      out  DATA_W    registered read data
//  count         out  ADDR_W+1  occupied entries, 0..DEPTH
//  full, empty   out  1         count==DEPTH / count==0
//  almost_full   out  1         count >= AF threshold
//  almost_empty  out  1         count <= AE threshold
//  overflow      out  1         sticky: push while full was dropped
//  underflow     out  1         sticky: pop while empty was ignored
// BEHAVIOUR
//  - Async reset and state==RESET: ptrs=0, count=0, data_out=0, overflow=underflow=0, AF=AF_RST, AE=AE_RST,
//    full=0, empty=1, almost_full=(0>=AF_RST), almost_empty=1. RAM contents are don't-care.
//  - INIT: latch umbral_AF_in/umbral_AE_in; FIFO contents and flags are held.
//  - IDLE: data_out<=0; pointers, count and flags are held; push/pop ignored.
//  - ACTIVE: push/pop are processed as listed below. Any non-one-hot state value: hold everything.
//  - Storage: DEPTH x DATA_W array, registered write. Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
//  - Push (not full): mem[wr_ptr]<=data_in, wr_ptr++, count++.
//  - Pop (not empty): data_out<=mem[rd_ptr] at that edge (1-cycle latency), rd_ptr++, count--.
//  - Pop on empty: underflow<=1; data_out, rd_ptr, count unchanged.
//  - Push on full: overflow<=1; data dropped; wr_ptr, count unchanged.
//  - Push+pop, 0<count<DEPTH: both proceed; count unchanged.
//  - Push+pop when full: both proceed (read old head, write into freed slot); count stays DEPTH; no overflow.
//  - Push+pop when empty: no bypass. Push proceeds, pop flags underflow, count becomes 1, data_out unchanged.
//  - Flags are registered from the next-count value, so they are coherent with count on every cycle.
//    AF/AE compares are unsigned, ADDR_W+1 bits wide.
//  - AE >= AF is legal: both almost flags may assert together.
//  - overflow/underflow stay set until reset or state==RESET.
//  - Reset asserted mid-transfer: all in-flight operations are abandoned; state is as listed at reset.
// TESTING (DATA_W=12, ADDR_W=3)
//  1. Reset, INIT with AF=6/AE=1, ACTIVE; push 0x001..0x008 -> count 1..8; almost_full from count 6; full at count 8; empty=0.
//  2. Continue: pop 8x -> data_out 0x001..0x008, each one cycle after its pop; empty at count 0; almost_empty at count<=1.
//  3. Full, push 0x0AA -> overflow=1, count=8. Pop 8x -> 0x001..0x008; 0x0AA is never output.
//  4. Empty, pop -> underflow=1, data_out holds. Push+pop on empty -> count=1, underflow stays 1.
//  5. Count=8: push+pop for 20 cycles with incrementing data -> count stays 8, output in order across pointer wraps, no overflow.
//  6. IDLE mid-stream -> data_out=0, count held. Async reset pulse between clock edges -> all outputs take reset values immediately.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with a registered read port, sticky error flags and
// programmable almost-full/almost-empty thresholds. It is sequenced by a one-hot state bus.
module fifo_param #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int AF_RST = 6,
  parameter int AE_RST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W:0]   umbral_AF_in,
  input  logic [ADDR_W:0]   umbral_AE_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_RST_C = (ADDR_W+1)'(AF_RST);
  localparam logic [ADDR_W:0]   AE_RST_C = (ADDR_W+1)'(AE_RST);
  localparam logic [ADDR_W:0]   CNT_ONE  = 'd1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 'd1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [ADDR_W:0]   af_thr_q, af_thr_d;
  logic [ADDR_W:0]   ae_thr_q, ae_thr_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic active;
  logic rd_ok;
  logic wr_ok;

  // A push into a full FIFO still proceeds when a pop frees the head slot in the same cycle.
  assign active = (state == ST_ACTIVE);
  assign rd_ok  = active && pop && !empty_q;
  assign wr_ok  = active && push && (!full_q || rd_ok);

  // NOTE: every next-state signal gets a default first so this block can never infer a latch.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    data_out_d     = data_out_q;
    af_thr_d       = af_thr_q;
    ae_thr_d       = ae_thr_q;
    full_d         = full_q;
    empty_d        = empty_q;
    almost_full_d  = almost_full_q;
    almost_empty_d = almost_empty_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;

    case (state)
      ST_RESET: begin
        wr_ptr_d       = '0;
        rd_ptr_d       = '0;
        count_d        = '0;
        data_out_d     = '0;
        af_thr_d       = AF_RST_C;
        ae_thr_d       = AE_RST_C;
        full_d         = 1'b0;
        empty_d        = 1'b1;
        almost_full_d  = (AF_RST_C == '0);
        almost_empty_d = 1'b1;
        overflow_d     = 1'b0;
        underflow_d    = 1'b0;
      end
      ST_INIT: begin
        af_thr_d = umbral_AF_in;
        ae_thr_d = umbral_AE_in;
      end
      ST_IDLE: begin
        data_out_d = '0;
      end
      ST_ACTIVE: begin
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_ok) begin
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          data_out_d = mem[rd_ptr_q];
        end
        case ({wr_ok, rd_ok})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
        if (push && !wr_ok) overflow_d  = 1'b1;
        if (pop && empty_q) underflow_d = 1'b1;
        // Flags come from the next count so they line up with count on the same cycle.
        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= af_thr_q);
        almost_empty_d = (count_d <= ae_thr_q);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      af_thr_q       <= AF_RST_C;
      ae_thr_q       <= AE_RST_C;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (AF_RST_C == '0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      af_thr_q       <= af_thr_d;
      ae_thr_q       <= ae_thr_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are unreachable until written, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[wr_ptr_q] <= data_in;
  end

  assign data_out     = data_out_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_fifo_param;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int AF_RST = 6;
  localparam int AE_RST = 1;

  localparam logic [3:0] S_RST  = 4'b0001;
  localparam logic [3:0] S_INIT = 4'b0010;
  localparam logic [3:0] S_IDLE = 4'b0100;
  localparam logic [3:0] S_ACT  = 4'b1000;

  logic              clk;
  logic              reset;
  logic [3:0]        state;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W:0]   umbral_AF_in;
  logic [ADDR_W:0]   umbral_AE_in;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  fifo_param #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .AF_RST(AF_RST),
    .AE_RST(AE_RST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .state        (state),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .umbral_AF_in (umbral_AF_in),
    .umbral_AE_in (umbral_AE_in),
    .data_out     (data_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue contents plus the observable registers.
  int q[$];
  int m_dout;
  int m_af_thr;
  int m_ae_thr;
  bit m_ovf, m_udf, m_full, m_empty, m_af, m_ae;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_flags();
    int n;
    n       = q.size();
    m_full  = (n == DEPTH);
    m_empty = (n == 0);
    m_af    = (n >= m_af_thr);
    m_ae    = (n <= m_ae_thr);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout   = 0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_af_thr = AF_RST;
    m_ae_thr = AE_RST;
    model_flags();
  endtask

  task automatic model_edge();
    bit was_full, was_empty, rd, wr;
    case (state)
      S_RST:  model_reset();
      S_INIT: begin
        m_af_thr = int'(umbral_AF_in);
        m_ae_thr = int'(umbral_AE_in);
      end
      S_IDLE: m_dout = 0;
      S_ACT: begin
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        rd = pop && !was_empty;
        wr = push && (!was_full || rd);
        if (pop && was_empty) m_udf = 1'b1;
        if (push && !wr)      m_ovf = 1'b1;
        if (rd) m_dout = q.pop_front();
        if (wr) q.push_back(int'(data_in));
        model_flags();
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},     32'(data_out),     32'(m_dout));
    chk({tag, ".count"},        32'(count),        32'(q.size()));
    chk({tag, ".full"},         32'(full),         32'(m_full));
    chk({tag, ".empty"},        32'(empty),        32'(m_empty));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(m_af));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_ae));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_udf));
  endtask

  task automatic cyc(input string tag, input logic [3:0] st, input logic pu, input logic po,
                     input int d);
    state   = st;
    push    = pu;
    pop     = po;
    data_in = DATA_W'(d);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int nxt;
    int r;
    logic [3:0] st;

    reset        = 1'b1;
    state        = S_RST;
    push         = 1'b0;
    pop          = 1'b0;
    data_in      = '0;
    umbral_AF_in = 4'd6;
    umbral_AE_in = 4'd1;
    model_reset();
    #1;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    cyc("rst_state", S_RST, 1'b0, 1'b0, 0);
    cyc("init", S_INIT, 1'b0, 1'b0, 0);

    // Fill to full, then drain in order.
    for (int i = 1; i <= 8; i++) cyc("t1_push", S_ACT, 1'b1, 1'b0, i);
    for (int i = 0; i < 8; i++)  cyc("t2_pop", S_ACT, 1'b0, 1'b1, 0);

    // Overflow: the dropped word must never come out.
    for (int i = 1; i <= 8; i++) cyc("t3_fill", S_ACT, 1'b1, 1'b0, i);
    cyc("t3_ovf", S_ACT, 1'b1, 1'b0, 'h0AA);
    for (int i = 0; i < 8; i++)  cyc("t3_pop", S_ACT, 1'b0, 1'b1, 0);

    // Underflow, then push+pop on empty with no bypass.
    cyc("t4_udf", S_ACT, 1'b0, 1'b1, 0);
    cyc("t4_pushpop_empty", S_ACT, 1'b1, 1'b1, 'h055);
    cyc("t4_drain", S_ACT, 1'b0, 1'b1, 0);

    // Simultaneous push+pop while full, across pointer wraps.
    nxt = 'h100;
    for (int i = 0; i < 8; i++) begin
      cyc("t5_fill", S_ACT, 1'b1, 1'b0, nxt);
      nxt++;
    end
    for (int i = 0; i < 20; i++) begin
      cyc("t5_pushpop_full", S_ACT, 1'b1, 1'b1, nxt);
      nxt++;
    end

    // IDLE clears data_out only; then an asynchronous reset pulse between edges.
    cyc("t6_idle", S_IDLE, 1'b1, 1'b1, 'h3FF);
    cyc("t6_active", S_ACT, 1'b0, 1'b1, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("t6_async_rst");
    #1;
    reset = 1'b0;

    cyc("rst_state2", S_RST, 1'b0, 1'b0, 0);
    cyc("init2", S_INIT, 1'b0, 1'b0, 0);

    // Random traffic with occasional state excursions and threshold changes.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85)      st = S_ACT;
      else if (r < 90) st = S_IDLE;
      else if (r < 95) st = S_INIT;
      else if (r < 97) st = S_RST;
      else             st = 4'($urandom_range(0, 15));
      umbral_AF_in = 4'($urandom_range(0, 15));
      umbral_AE_in = 4'($urandom_range(0, 15));
      cyc("rand", st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 4095)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
